// File: rtl/alu_cmd_issuer_if.sv
// Bundle of the command, ALU and response channels of the ALU command issuer.
// A transfer happens on a rising edge where valid && ready; the source keeps its payload stable while valid && !ready.
interface alu_cmd_issuer_if #(
    parameter int DEPTH = 4
);
    localparam int PW = $clog2(DEPTH + 1);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_a;
    logic [7:0]    cmd_b;
    logic [2:0]    cmd_op;

    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [2:0]    alu_op;
    logic          alu_start;
    logic          alu_done;
    logic [15:0]   alu_result;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_result;
    logic [2:0]    rsp_op;
    logic          rsp_err;

    logic [PW-1:0] pending;
    logic [2:0]    state_dbg;

    // master: the issuer itself; slave: command source, ALU and response sink
    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, alu_start,
               rsp_valid, rsp_result, rsp_op, rsp_err, pending, state_dbg
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, alu_start,
               rsp_valid, rsp_result, rsp_op, rsp_err, pending, state_dbg
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands in a FIFO and runs them one at a time through the ALU start/done
// handshake, returning each result (or error) on the response channel.
module alu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input logic              clk,
    input logic              rst_n,
    alu_cmd_issuer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_NOP   = 3'd2,
        S_GAP   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t         state_q, state_d;

    logic [18:0]    fifo_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]  count_q;

    logic [7:0]     alu_a_q, alu_b_q;
    logic [2:0]     alu_op_q;
    logic [2:0]     rsp_op_q;
    logic [15:0]    res_q;
    logic           err_q;
    logic [TW-1:0]  tmo_q;

    logic [7:0]     head_a, head_b;
    logic [2:0]     head_op;
    logic           fifo_empty, fifo_full, push, pop;
    logic           head_to_alu, head_legal, tmo_hit;

    assign {head_op, head_a, head_b} = fifo_q[rd_ptr_q];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == PW'(DEPTH));
    assign push       = bus.cmd_valid && bus.cmd_ready;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;

    assign head_to_alu = (head_op == OP_ADD) || (head_op == OP_AND) ||
                         (head_op == OP_XOR) || (head_op == OP_MUL);
    assign head_legal  = head_to_alu || (head_op == OP_NOP) || (head_op == OP_RST);
    assign tmo_hit     = (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_to_alu)            state_d = S_ISSUE;
                    else if (head_op == OP_NOP) state_d = S_NOP;
                    else                        state_d = S_RESP;
                end
            end
            S_ISSUE: if (bus.alu_done || tmo_hit) state_d = S_GAP;
            S_NOP:   state_d = S_GAP;
            S_GAP:   state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.alu_start = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            S_ISSUE, S_NOP: bus.alu_start = 1'b1;
            S_RESP:         bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{(PW-1){1'b0}}, push} - {{(PW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rsp_op_q <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        rsp_op_q <= head_op;
                        res_q    <= '0;
                        err_q    <= !head_legal;
                        tmo_q    <= '0;
                        // rst_op and illegal opcodes never reach the ALU, so its inputs stay untouched
                        if (head_to_alu || (head_op == OP_NOP)) begin
                            alu_a_q  <= head_a;
                            alu_b_q  <= head_b;
                            alu_op_q <= head_op;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.alu_done) begin
                        res_q <= bus.alu_result;
                        err_q <= 1'b0;
                    end else if (tmo_hit) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_NOP: begin
                    res_q <= bus.alu_result;
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = rst_n && !fifo_full;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_err    = err_q;
    assign bus.pending    = count_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed scenarios plus random traffic, checked every cycle
// against an in-order queue of expected responses and a reactive ALU model.
module tb_alu_cmd_issuer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.DEPTH(DEPTH)) bus ();

    alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [5:0]  lat;     // ALU latency in start-high cycles, 0 = never done
        logic [15:0] res;
        logic        err;
        logic [5:0]  starts;  // expected number of alu_start-high cycles
    } exp_t;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  op;
        logic        err;
        logic [5:0]  starts;
        logic [7:0]  vcnt;
    } log_t;

    exp_t exp_q[$];
    log_t log_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int start_hi   = 0;
    int vcnt       = 0;
    bit dispatched = 0;
    bit saw_full   = 0;
    int hold_low   = 0;
    bit rand_rdy   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got an unexpected or missing event, required the specified one", name);
    endtask

    // Response the issuer must produce for one command, from the opcode rules.
    function automatic exp_t model_rsp(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op, input int lat);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.lat = 6'(lat);
        e.res = '0; e.err = 1'b0; e.starts = '0;
        case (op)
            3'd1, 3'd2, 3'd3, 3'd4: begin
                if (lat == 0) begin
                    e.err    = 1'b1;
                    e.starts = 6'(TIMEOUT);
                end else begin
                    e.starts = 6'(lat);
                    case (op)
                        3'd1:    e.res = 16'(a) + 16'(b);
                        3'd2:    e.res = {8'h00, a & b};
                        3'd3:    e.res = {8'h00, a ^ b};
                        default: e.res = 16'(a) * 16'(b);
                    endcase
                end
            end
            3'd0: begin
                e.res    = {a ^ 8'h5A, b ^ 8'hC3};
                e.starts = 6'd1;
            end
            3'd7:    e.res = '0;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // ALU model: real result when done, otherwise a value derived from the operands.
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op, input logic done);
        if (!done) return {a ^ 8'h5A, b ^ 8'hC3};
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'hDEAD;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_done);

    always @(posedge clk) begin
        int pend_exp;
        #1;
        if (!rst_n) begin
            chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("rst_alu_start", 32'(bus.alu_start), 32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_pending", 32'(bus.pending), 32'd0);
            chk("rst_alu_opnds", {8'h00, bus.alu_a, bus.alu_b, 5'd0, bus.alu_op}, 32'd0);
            chk("rst_rsp_fields", {12'd0, bus.rsp_result, bus.rsp_op, bus.rsp_err}, 32'd0);
            exp_q.delete();
            dispatched = 0;
            start_hi = 0;
            vcnt = 0;
            bus.alu_done = 1'b0;
            bus.rsp_ready = 1'b0;
        end else begin
            if (bus.alu_start) begin
                dispatched = 1;
                start_hi++;
                if (exp_q.size() == 0) begin
                    fail_now("stray_alu_start");
                end else begin
                    chk("alu_a", 32'(bus.alu_a), 32'(exp_q[0].a));
                    chk("alu_b", 32'(bus.alu_b), 32'(exp_q[0].b));
                    chk("alu_op", 32'(bus.alu_op), 32'(exp_q[0].op));
                end
            end
            if (bus.rsp_valid) begin
                dispatched = 1;
                vcnt++;
                if (exp_q.size() == 0) begin
                    fail_now("stray_rsp_valid");
                end else begin
                    chk("rsp_result", 32'(bus.rsp_result), 32'(exp_q[0].res));
                    chk("rsp_op", 32'(bus.rsp_op), 32'(exp_q[0].op));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
                end
            end
            pend_exp = exp_q.size() - (dispatched ? 1 : 0);
            chk("pending", 32'(bus.pending), 32'(pend_exp));
            chk("cmd_ready", 32'(bus.cmd_ready), (pend_exp < DEPTH) ? 32'd1 : 32'd0);
            if ((32'(bus.pending) == DEPTH) && !bus.cmd_ready) saw_full = 1;

            if (bus.alu_start && exp_q.size() > 0 && exp_q[0].op inside {[3'd1:3'd4]})
                bus.alu_done = (exp_q[0].lat != 0) && (start_hi == int'(exp_q[0].lat));
            else if (bus.alu_start)
                bus.alu_done = 1'b0;
            else
                bus.alu_done = 1'($urandom_range(0, 1));

            if (bus.rsp_valid && hold_low > 0) begin
                bus.rsp_ready = 1'b0;
                hold_low--;
            end else if (rand_rdy) begin
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.rsp_ready = 1'b1;
            end

            if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
                chk("start_cycles", 32'(start_hi), 32'(exp_q[0].starts));
                log_q.push_back({bus.rsp_result, bus.rsp_op, bus.rsp_err, 6'(start_hi), 8'(vcnt)});
                void'(exp_q.pop_front());
                dispatched = 0;
                start_hi = 0;
                vcnt = 0;
            end
        end
    end

    // Called at a falling edge; returns at a falling edge after the command was accepted.
    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int lat);
        int guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_op = op;
        while (!bus.cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.cmd_ready) begin
            fail_now("push_timeout");
            bus.cmd_valid = 1'b0;
            return;
        end
        exp_q.push_back(model_rsp(a, b, op, lat));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start();
        int guard = 0;
        while (!bus.alu_start && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.alu_start) fail_now("start_timeout");
    endtask

    task automatic chk_log(input string tag, input logic [15:0] res, input logic [2:0] op,
                           input logic err, input int starts);
        log_t l;
        if (log_q.size() == 0) begin
            fail_now({tag, "_missing"});
            return;
        end
        l = log_q.pop_front();
        chk({tag, "_result"}, 32'(l.res), 32'(res));
        chk({tag, "_op"}, 32'(l.op), 32'(op));
        chk({tag, "_err"}, 32'(l.err), 32'(err));
        chk({tag, "_starts"}, 32'(l.starts), 32'(starts));
    endtask

    initial begin
        log_t l;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_op = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // add with 1-cycle ALU latency
        push_cmd(8'hFF, 8'h01, 3'b001, 1);
        drain();
        chk_log("add_ff_01", 16'h0100, 3'b001, 1'b0, 1);

        // mul with 3-cycle latency, response held off for 5 cycles
        hold_low = 5;
        push_cmd(8'hFF, 8'hFF, 3'b100, 3);
        drain();
        if (log_q.size() > 0) chk("mul_valid_cycles", 32'(log_q[0].vcnt), 32'd6);
        chk_log("mul_ff_ff", 16'hFE01, 3'b100, 1'b0, 3);

        // fill the FIFO while a slow command is in ISSUE
        push_cmd(8'h10, 8'h20, 3'b001, 10);
        wait_start();
        for (int i = 0; i < 5; i++)
            push_cmd(8'(i + 1), 8'(i + 2), 3'(1 + (i % 4)), 1 + (i % 3));
        drain();
        chk("fifo_full_seen", 32'(saw_full), 32'd1);
        chk("fill_rsp_count", 32'(log_q.size()), 32'd6);
        chk_log("fill_first", 16'h0030, 3'b001, 1'b0, 10);
        if (log_q.size() > 0) begin
            l = log_q[0];
            chk("fill_second_result", 32'(l.res), 32'h0003);
        end
        log_q.delete();

        // no_op, rst_op and an illegal opcode
        push_cmd(8'h03, 8'h04, 3'b000, 0);
        push_cmd(8'h00, 8'h00, 3'b111, 0);
        push_cmd(8'h12, 8'h34, 3'b101, 0);
        drain();
        chk_log("nop", 16'h59C7, 3'b000, 1'b0, 1);
        chk_log("rstop", 16'h0000, 3'b111, 1'b0, 0);
        chk_log("illegal", 16'h0000, 3'b101, 1'b1, 0);

        // ALU never answers, next command runs normally
        push_cmd(8'h01, 8'h02, 3'b001, 0);
        push_cmd(8'h05, 8'h06, 3'b011, 2);
        drain();
        chk_log("timeout", 16'h0000, 3'b001, 1'b1, TIMEOUT);
        chk_log("after_timeout", 16'h0003, 3'b011, 1'b0, 2);

        // reset in the middle of ISSUE with two commands queued
        push_cmd(8'h09, 8'h09, 3'b001, 0);
        push_cmd(8'h01, 8'h01, 3'b001, 1);
        push_cmd(8'h02, 8'h02, 3'b010, 1);
        wait_start();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        repeat (60) @(negedge clk);
        chk("no_rsp_after_reset", 32'(log_q.size()), 32'd0);

        // random traffic
        rand_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            logic [2:0] rop;
            int rlat;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rop = 3'($urandom_range(0, 7));
            rlat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            push_cmd(ra, rb, rop, rlat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        chk("random_rsp_count", 32'(log_q.size()), 32'd60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
